coin_credit_unit: RTL and testbench

Payment front end of the vending machine: detects coin pulses, accumulates credit, and compares it against the price of the item chosen by the selector FSM (`SA`). It drives the credit code `CIN` and enable `E` consumed by the dispenser FSM. It also deducts the price when the dispenser reports completion, and pays back change or refunds one unit per pulse.

---
 rtl/coin_credit_unit.sv | 187 ++++++++++++++++++
 tb/tb_coin_credit_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_unit.sv
`default_nettype none
// =============================================================================
// Module   : coin_credit_unit
// Brief    : Vending-machine payment front end: coin edge detect, credit,
//            price compare, debit on vend completion, change/refund pulses.
//            Optional input synchronizers enabled by macro COIN_SYNC_EN.
// Revision : 1.0 - initial release
// =============================================================================
module coin_credit_unit #(
  parameter int MAX_CREDIT = 7,
  parameter int CHG_GAP    = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       COIN1,
  input  logic       COIN2,
  input  logic       CANCEL,
  input  logic [3:0] SA,
  input  logic       VEND_ACK,
  input  logic       VEND_DONE,
  output logic [2:0] CIN,
  output logic       E,
  output logic       CHG,
  output logic       REJ,
  output logic       BUSY
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_COLLECT = 3'd1;
  localparam logic [2:0] c_READY   = 3'd2;
  localparam logic [2:0] c_VEND    = 3'd3;
  localparam logic [2:0] c_PAYOUT  = 3'd4;

  localparam logic [3:0] c_MAX = 4'(MAX_CREDIT);
  localparam logic [2:0] c_GAP = 3'(CHG_GAP);

  logic [2:0] w_raw;
  logic [2:0] w_lvl;
  assign w_raw = {CANCEL, COIN2, COIN1};

`ifdef COIN_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end
  assign w_lvl = r_sync2;
`else
  assign w_lvl = w_raw;
`endif

  logic [2:0] r_hist;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_hist <= '0;
    else        r_hist <= w_lvl;
  end

  logic [2:0] w_edge;
  logic       w_coin1, w_coin2, w_cancel, w_any_coin;
  assign w_edge     = w_lvl & ~r_hist;
  assign w_coin1    = w_edge[0];
  assign w_coin2    = w_edge[1];
  assign w_cancel   = w_edge[2];
  assign w_any_coin = w_coin1 | w_coin2;

  logic [2:0] r_state, r_credit, r_price, r_gap;
  logic       r_chg, r_rej, r_e, r_busy;

  logic [3:0] w_sum, w_price4;
  logic [2:0] w_price, w_left;
  logic       w_fits, w_afford, w_open, w_unused;

  // SA[2] does not take part in pricing
  assign w_unused   = SA[2];
  assign w_sum      = {1'b0, r_credit} + {2'b00, w_coin2, w_coin1};
  assign w_fits     = (w_sum <= c_MAX);
  assign w_price4   = 4'd4 + {2'b00, SA[1:0]};
  assign w_price    = (w_price4 > 4'd7) ? 3'd7 : w_price4[2:0];
  assign w_afford   = SA[3] && (r_credit >= w_price);
  assign w_left     = r_credit - r_price;
  assign w_open     = (r_state == c_IDLE) || (r_state == c_COLLECT) || (r_state == c_READY);

  logic [2:0] w_state_nxt, w_credit_nxt, w_price_nxt, w_gap_nxt;
  logic       w_chg_nxt, w_rej_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_price_nxt  = r_price;
    w_gap_nxt    = r_gap;
    w_chg_nxt    = 1'b0;
    w_rej_nxt    = 1'b0;

    // Deposits only count while no sale or payout is in progress
    if (w_open) begin
      if (w_any_coin) begin
        if (w_fits) w_credit_nxt = w_sum[2:0];
        else        w_rej_nxt    = 1'b1;
      end
    end else begin
      w_rej_nxt = w_any_coin;
    end

    case (r_state)
      c_IDLE: begin
        if (w_any_coin && w_fits) w_state_nxt = c_COLLECT;
      end
      c_COLLECT: begin
        if (w_cancel) begin
          w_state_nxt = c_PAYOUT;
          w_gap_nxt   = '0;
        end else if (w_afford) begin
          w_state_nxt = c_READY;
        end
      end
      c_READY: begin
        if (VEND_ACK) begin
          w_state_nxt = c_VEND;
          w_price_nxt = w_price;
        end else if (w_cancel) begin
          w_state_nxt = c_PAYOUT;
          w_gap_nxt   = '0;
        end else if (!w_afford) begin
          w_state_nxt = c_COLLECT;
        end
      end
      c_VEND: begin
        if (VEND_DONE) begin
          w_credit_nxt = w_left;
          w_gap_nxt    = '0;
          w_state_nxt  = (w_left != 3'd0) ? c_PAYOUT : c_IDLE;
        end
      end
      c_PAYOUT: begin
        // r_gap == 0 marks the cycle where the next unit may be paid
        if (r_gap == 3'd0) begin
          if (r_credit != 3'd0) begin
            w_chg_nxt    = 1'b1;
            w_credit_nxt = r_credit - 3'd1;
            w_gap_nxt    = c_GAP;
          end else begin
            w_state_nxt  = c_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap - 3'd1;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= c_IDLE;
      r_credit <= '0;
      r_price  <= '0;
      r_gap    <= '0;
      r_chg    <= 1'b0;
      r_rej    <= 1'b0;
      r_e      <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_price  <= w_price_nxt;
      r_gap    <= w_gap_nxt;
      r_chg    <= w_chg_nxt;
      r_rej    <= w_rej_nxt;
      r_e      <= (w_state_nxt == c_READY);
      r_busy   <= (w_state_nxt == c_VEND) || (w_state_nxt == c_PAYOUT);
    end
  end

  assign CIN  = r_credit;
  assign E    = r_e;
  assign CHG  = r_chg;
  assign REJ  = r_rej;
  assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_coin_credit_unit
// Brief    : Directed plus randomized bench with a credit/payout reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_coin_credit_unit;

  localparam int MAX = 7;
  localparam int GAP = 2;
`ifdef COIN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       COIN1 = 1'b0, COIN2 = 1'b0, CANCEL = 1'b0;
  logic [3:0] SA = 4'b0000;
  logic       VEND_ACK = 1'b0, VEND_DONE = 1'b0;
  logic [2:0] CIN;
  logic       E, CHG, REJ, BUSY;

  coin_credit_unit #(.MAX_CREDIT(MAX), .CHG_GAP(GAP)) dut (
    .CLK(CLK), .RESET(RESET), .COIN1(COIN1), .COIN2(COIN2), .CANCEL(CANCEL),
    .SA(SA), .VEND_ACK(VEND_ACK), .VEND_DONE(VEND_DONE),
    .CIN(CIN), .E(E), .CHG(CHG), .REJ(REJ), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int  n_vec = 0;
  int  n_err = 0;
  int  m_credit = 0;
  bit  m_locked = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int price_of(input logic [3:0] sa);
    int p;
    p = 4 + int'(sa[1:0]);
    if (p > 7) p = 7;
    return p;
  endfunction

  function automatic int exp_e();
    if (m_locked || !SA[3]) return 0;
    return (m_credit >= price_of(SA)) ? 1 : 0;
  endfunction

  task automatic coin(input bit c1, input bit c2);
    int  sum;
    bit  acc;
    sum = m_credit + (c2 ? 2 : 0) + (c1 ? 1 : 0);
    acc = !m_locked && (sum <= MAX);
    COIN1 = c1;
    COIN2 = c2;
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      chk("cin_latency", int'(CIN), m_credit);
    end
    step();
    if (acc) m_credit = sum;
    chk("cin_deposit", int'(CIN), m_credit);
    chk("rej", int'(REJ), acc ? 0 : 1);
    COIN1 = 1'b0;
    COIN2 = 1'b0;
    step();
    chk("rej_one_cycle", int'(REJ), 0);
    step();
  endtask

  task automatic expect_payout(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("chg_high", int'(CHG), 1);
      m_credit--;
      chk("cin_payout", int'(CIN), m_credit);
      for (int g = 0; g < GAP; g++) begin
        step();
        chk("chg_gap", int'(CHG), 0);
        chk("busy_gap", int'(BUSY), 1);
      end
    end
    step();
    chk("busy_end", int'(BUSY), 0);
    chk("chg_end", int'(CHG), 0);
    m_locked = 0;
  endtask

  task automatic cancel_refund();
    int n;
    n = m_credit;
    CANCEL = 1'b1;
    repeat (LAT) step();
    CANCEL = 1'b0;
    m_locked = 1;
    chk("cancel_busy", int'(BUSY), 1);
    chk("cancel_e", int'(E), 0);
    chk("cancel_cin", int'(CIN), n);
    expect_payout(n);
  endtask

  task automatic vend(input bit poke);
    int p;
    p = price_of(SA);
    VEND_ACK = 1'b1;
    step();
    VEND_ACK = 1'b0;
    m_locked = 1;
    chk("ack_busy", int'(BUSY), 1);
    chk("ack_e", int'(E), 0);
    if (poke) begin
      coin(1'b0, 1'b1);
      CANCEL = 1'b1;
      repeat (LAT + 1) step();
      CANCEL = 1'b0;
      step();
      chk("vend_cancel_busy", int'(BUSY), 1);
      chk("vend_cancel_chg", int'(CHG), 0);
      chk("vend_cancel_cin", int'(CIN), m_credit);
    end
    SA = 4'(($urandom_range(0, 15)));
    VEND_DONE = 1'b1;
    step();
    VEND_DONE = 1'b0;
    m_credit = m_credit - p;
    chk("debit_cin", int'(CIN), m_credit);
    chk("debit_busy", int'(BUSY), (m_credit != 0) ? 1 : 0);
    chk("debit_chg", int'(CHG), 0);
    if (m_credit != 0) expect_payout(m_credit);
    else m_locked = 0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cin", int'(CIN), 0);
    chk("rst_e", int'(E), 0);
    chk("rst_chg", int'(CHG), 0);
    chk("rst_rej", int'(REJ), 0);
    chk("rst_busy", int'(BUSY), 0);
    #11 RESET = 1'b1;
    step();

    // Exact payment
    SA = 4'b1010;
    repeat (3) coin(1'b0, 1'b1);
    chk("exact_e", int'(E), exp_e());
    vend(1'b1);
    repeat (3) begin step(); chk("exact_no_chg", int'(CHG), 0); end

    // Change
    SA = 4'b1000;
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    chk("change_e", int'(E), 1);
    coin(1'b0, 1'b1);
    vend(1'b0);

    // Overflow
    SA = 4'b0000;
    repeat (3) coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    chk("overflow_cin", int'(CIN), 7);
    cancel_refund();

    // Simultaneous coins then cancel
    coin(1'b1, 1'b1);
    chk("simul_cin", int'(CIN), 3);
    cancel_refund();

    // Selection change
    SA = 4'b1000;
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    chk("sel_ready_e", int'(E), 1);
    SA = 4'b1011;
    step();
    chk("sel_drop_e", int'(E), 0);
    coin(1'b0, 1'b1);
    chk("sel_cin7", int'(CIN), 7);
    chk("sel_e_again", int'(E), 1);

    // Reset in the middle of a refund
    CANCEL = 1'b1;
    repeat (LAT) step();
    CANCEL = 1'b0;
    step();
    chk("pre_rst_chg", int'(CHG), 1);
    #3 RESET = 1'b0;
    #1;
    chk("arst_cin", int'(CIN), 0);
    chk("arst_chg", int'(CHG), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_e", int'(E), 0);
    #2 RESET = 1'b1;
    m_credit = 0;
    m_locked = 0;
    repeat (6) begin
      step();
      chk("post_rst_chg", int'(CHG), 0);
      chk("post_rst_cin", int'(CIN), 0);
    end

    // Randomized sales and refunds
    for (int it = 0; it < 25; it++) begin
      SA = {1'b1, 3'(($urandom_range(0, 7)))};
      for (int c = 0; c < 10 && m_credit < price_of(SA); c++) begin
        case ($urandom_range(0, 2))
          0:       coin(1'b1, 1'b0);
          1:       coin(1'b0, 1'b1);
          default: coin(1'b1, 1'b1);
        endcase
      end
      chk("rnd_e", int'(E), exp_e());
      if ($urandom_range(0, 1) == 1) begin
        coin($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        chk("rnd_extra_e", int'(E), exp_e());
      end
      if ($urandom_range(0, 2) == 0) begin
        SA = 4'(($urandom_range(0, 15)));
        step();
        step();
        chk("rnd_sel_e", int'(E), exp_e());
      end
      if (exp_e() == 1 && $urandom_range(0, 2) != 0) vend($urandom_range(0, 1) == 1);
      else if (m_credit != 0) cancel_refund();
      chk("rnd_idle_cin", int'(CIN), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
